// File: rtl/resilient_stage_ctrl_pkg.sv
// Shared types and width helpers for the error-resilient stage controller.
package resilient_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_SAMPLE  = 3'd2,
      ST_RECOVER = 3'd3,
      ST_OUT     = 3'd4
   } state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned ctr_w(input int unsigned max_val);
      return (max_val < 32'd2) ? 32'd1 : $clog2(max_val + 32'd1);
   endfunction

endpackage

// File: rtl/resilient_stage_ctrl_err_window_monitor.sv
// Sliding-window error-rate monitor: counts sampled tokens and errored samples
// per window and decides slow_mode at the end of each window.
module err_window_monitor
   import resilient_pkg::*;
#(
   parameter int unsigned WIN_LEN    = 16,
   parameter int unsigned ERR_THRESH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_evt,
   input  logic err_evt,
   output logic slow_mode
);

   localparam int unsigned      TOK_W    = ctr_w(WIN_LEN - 32'd1);
   localparam int unsigned      ERR_W    = ctr_w(WIN_LEN);
   localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(WIN_LEN - 32'd1);
   localparam logic [TOK_W-1:0] TOK_ONE  = TOK_W'(32'd1);
   localparam logic [ERR_W-1:0] THRESH   = ERR_W'(ERR_THRESH);

   logic [TOK_W-1:0] tok_q, tok_d;
   logic [ERR_W-1:0] errs_q, errs_d, errs_sum_s;
   logic             slow_q, slow_d;

   // The closing token's own error is folded in before the threshold compare.
   always_comb begin
      errs_sum_s = errs_q + ERR_W'(err_evt);
      tok_d      = tok_q;
      errs_d     = errs_q;
      slow_d     = slow_q;
      if (sample_evt) begin
         if (tok_q == TOK_LAST) begin
            tok_d  = {TOK_W{1'b0}};
            errs_d = {ERR_W{1'b0}};
            if (errs_sum_s >= THRESH) begin
               slow_d = 1'b1;
            end else if (errs_sum_s == {ERR_W{1'b0}}) begin
               slow_d = 1'b0;
            end else begin
               slow_d = slow_q;
            end
         end else begin
            tok_d  = tok_q + TOK_ONE;
            errs_d = errs_sum_s;
         end
      end else begin
         tok_d  = tok_q;
         errs_d = errs_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tok_q  <= {TOK_W{1'b0}};
         errs_q <= {ERR_W{1'b0}};
         slow_q <= 1'b0;
      end else begin
         tok_q  <= tok_d;
         errs_q <= errs_d;
         slow_q <= slow_d;
      end
   end

   assign slow_mode = slow_q;

endmodule

// File: rtl/resilient_stage_ctrl.sv
// Controller for one error-resilient pipeline stage: captures a token, pulses
// the error-detecting latches, inserts recovery on error, then releases it.
module resilient_stage_ctrl
   import resilient_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ERR_LANES  = 2,
   parameter int unsigned EDL_WAIT   = 1,
   parameter int unsigned SLOW_EXTRA = 2,
   parameter int unsigned RECOV_CYC  = 2,
   parameter int unsigned WIN_LEN    = 16,
   parameter int unsigned ERR_THRESH = 3,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic                 sample,
   input  logic [ERR_LANES-1:0] err,
   input  logic                 clr_stats,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [ERR_LANES-1:0] err_sticky,
   output logic                 slow_mode
);

   localparam int unsigned      WAIT_MAX = EDL_WAIT + SLOW_EXTRA;
   localparam int unsigned      TMR_MAX  = (WAIT_MAX > RECOV_CYC) ? WAIT_MAX : RECOV_CYC;
   localparam int unsigned      TMR_W    = ctr_w(TMR_MAX);
   localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);
   localparam logic [TMR_W-1:0] LD_NORM  = TMR_W'(EDL_WAIT);
   localparam logic [TMR_W-1:0] LD_SLOW  = TMR_W'(WAIT_MAX);
   localparam logic [TMR_W-1:0] LD_RECOV = TMR_W'(RECOV_CYC - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   sample_q, sample_d;
   logic                   out_valid_q, out_valid_d;
   logic                   idle_rdy_q, idle_rdy_d;
   logic [CNT_W-1:0]       err_cnt_q, err_cnt_d, cnt_base_s;
   logic [ERR_LANES-1:0]   err_sticky_q, err_sticky_d, sticky_base_s;
   logic                   accept_s, sample_evt_s, err_evt_s, slow_s;
   logic [TMR_W-1:0]       wait_ld_s;

   // idle_rdy_q lags state by one edge so in_ready stays low through reset.
   assign in_ready     = idle_rdy_q | (out_valid_q & out_ready);
   assign accept_s     = in_valid & in_ready;
   assign sample_evt_s = (state_q == ST_SAMPLE);
   assign err_evt_s    = sample_evt_s & (|err);
   assign wait_ld_s    = slow_s ? LD_SLOW : LD_NORM;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_WAIT;
               tmr_d   = wait_ld_s;
               data_d  = in_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (tmr_q == TMR_ZERO) begin
               state_d = ST_SAMPLE;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         ST_SAMPLE: begin
            if (|err) begin
               state_d = ST_RECOVER;
               tmr_d   = LD_RECOV;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_RECOVER: begin
            if (tmr_q == TMR_ZERO) begin
               state_d = ST_OUT;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               if (accept_s) begin
                  state_d = ST_WAIT;
                  tmr_d   = wait_ld_s;
                  data_d  = in_data;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_OUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sample_d    = 1'b0;
      out_valid_d = 1'b0;
      idle_rdy_d  = 1'b0;
      case (state_d)
         ST_IDLE:   idle_rdy_d  = 1'b1;
         ST_SAMPLE: sample_d    = 1'b1;
         ST_OUT:    out_valid_d = 1'b1;
         default:   sample_d    = 1'b0;
      endcase
   end

   // A clear in the same cycle as an errored sample is applied before the update.
   always_comb begin
      cnt_base_s    = clr_stats ? {CNT_W{1'b0}} : err_cnt_q;
      sticky_base_s = clr_stats ? {ERR_LANES{1'b0}} : err_sticky_q;
      err_cnt_d     = cnt_base_s;
      err_sticky_d  = sticky_base_s;
      if (err_evt_s) begin
         err_cnt_d    = (cnt_base_s == CNT_MAX) ? cnt_base_s : cnt_base_s + CNT_ONE;
         err_sticky_d = sticky_base_s | err;
      end else begin
         err_cnt_d    = cnt_base_s;
         err_sticky_d = sticky_base_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tmr_q        <= TMR_ZERO;
         data_q       <= {DATA_W{1'b0}};
         sample_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         idle_rdy_q   <= 1'b0;
         err_cnt_q    <= {CNT_W{1'b0}};
         err_sticky_q <= {ERR_LANES{1'b0}};
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         data_q       <= data_d;
         sample_q     <= sample_d;
         out_valid_q  <= out_valid_d;
         idle_rdy_q   <= idle_rdy_d;
         err_cnt_q    <= err_cnt_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   err_window_monitor #(
      .WIN_LEN    (WIN_LEN),
      .ERR_THRESH (ERR_THRESH)
   ) u_win (
      .clk        (clk),
      .rst        (rst),
      .sample_evt (sample_evt_s),
      .err_evt    (err_evt_s),
      .slow_mode  (slow_s)
   );

   assign out_valid  = out_valid_q;
   assign out_data   = data_q;
   assign sample     = sample_q;
   assign err_cnt    = err_cnt_q;
   assign err_sticky = err_sticky_q;
   assign slow_mode  = slow_s;

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Scoreboard bench: driver plans each token through a reference model, an
// error driver answers sample pulses, a monitor checks every released token.
module tb_resilient_stage_ctrl;

   localparam int EDL   = 1;
   localparam int SLOW  = 2;
   localparam int RECOV = 2;
   localparam int WIN   = 16;
   localparam int THR   = 3;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, sample, clr_stats, slow_mode;
   logic [31:0] in_data, out_data;
   logic [1:0]  err, err_sticky;
   logic [7:0]  err_cnt;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  e;
      bit          clr;
      int          acc_edge;
      int          lat;
      int          samp_off;
      int          cnt;
      logic [1:0]  sticky;
      bit          slow;
   } rec_t;

   rec_t exp_q[$];
   rec_t plan_q[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   bit   b2b_chk = 0;

   int         m_cnt, m_wtok, m_werr;
   logic [1:0] m_sticky;
   bit         m_slow;

   resilient_stage_ctrl #(
      .DATA_W(32), .ERR_LANES(2), .EDL_WAIT(EDL), .SLOW_EXTRA(SLOW), .RECOV_CYC(RECOV),
      .WIN_LEN(WIN), .ERR_THRESH(THR), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sample(sample),
      .err(err), .clr_stats(clr_stats), .err_cnt(err_cnt), .err_sticky(err_sticky),
      .slow_mode(slow_mode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, expv, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: wait bound expired or event unexpected, cycle=%0d", name, cyc);
   endtask

   task automatic model_reset();
      m_cnt = 0; m_wtok = 0; m_werr = 0; m_sticky = 2'b00; m_slow = 1'b0;
   endtask

   // Reference behaviour of one token, derived from the latency/statistics rules.
   task automatic model_plan(input logic [31:0] d, input logic [1:0] e, input bit clr, output rec_t r);
      int base_lat;
      base_lat   = EDL + 2 + (m_slow ? SLOW : 0);
      r.data     = d;
      r.e        = e;
      r.clr      = clr;
      r.acc_edge = cyc + 1;
      r.samp_off = base_lat - 1;
      r.lat      = base_lat + ((e != 2'b00) ? RECOV : 0);
      if (clr) begin
         m_cnt = 0; m_sticky = 2'b00;
      end
      if (e != 2'b00) begin
         if (m_cnt < 255) m_cnt++;
         m_sticky = m_sticky | e;
         m_werr++;
      end
      m_wtok++;
      if (m_wtok == WIN) begin
         if (m_werr >= THR) m_slow = 1'b1;
         else if (m_werr == 0) m_slow = 1'b0;
         m_wtok = 0; m_werr = 0;
      end
      r.cnt    = m_cnt;
      r.sticky = m_sticky;
      r.slow   = m_slow;
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] e, input bit clr, input bit keep);
      rec_t r;
      bit   got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            model_plan(d, e, clr, r);
            exp_q.push_back(r);
            plan_q.push_back(r);
            got = 1'b1;
         end
      end
      if (!got) fail_bound("accept_wait");
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && plan_q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) fail_bound("idle_wait");
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_sample"}, sample, 1'b0);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_err_cnt"}, err_cnt, 8'h00);
      chk({tag, "_err_sticky"}, err_sticky, 2'b00);
      chk({tag, "_slow_mode"}, slow_mode, 1'b0);
      chk({tag, "_out_data"}, out_data, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      plan_q.delete();
      model_reset();
      @(posedge clk); #1;
   endtask

   // Downstream ready: 0 = always ready, 1 = random, otherwise stalled.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Error-latch model: answers each sample pulse with the planned lane errors.
   initial begin
      rec_t pr;
      bit   prev_s;
      err = 2'b00; clr_stats = 1'b0; prev_s = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            err = 2'b00; clr_stats = 1'b0; prev_s = 1'b0;
         end else begin
            if (sample) begin
               chk("sample_not_consecutive", prev_s, 1'b0);
               if (plan_q.size() == 0) begin
                  fail_bound("unexpected_sample");
               end else begin
                  pr = plan_q.pop_front();
                  chk("sample_offset", cyc - pr.acc_edge, pr.samp_off);
                  err = pr.e;
                  clr_stats = pr.clr;
               end
            end else begin
               err = 2'($urandom);
               clr_stats = 1'b0;
            end
            prev_s = sample;
         end
      end
   end

   // Monitor: compares each token on its first out_valid cycle, then its hold.
   initial begin
      rec_t        r;
      bit          presenting;
      logic [31:0] cur_data;
      presenting = 1'b0;
      cur_data = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            presenting = 1'b0;
         end else begin
            if (out_valid && !presenting) begin
               if (exp_q.size() == 0) begin
                  fail_bound("unexpected_out_valid");
               end else begin
                  r = exp_q.pop_front();
                  chk("latency", cyc - r.acc_edge, r.lat);
                  chk("out_data", out_data, r.data);
                  chk("err_cnt", err_cnt, r.cnt);
                  chk("err_sticky", err_sticky, r.sticky);
                  chk("slow_mode", slow_mode, r.slow);
                  cur_data = r.data;
               end
               presenting = 1'b1;
            end else if (out_valid) begin
               chk("out_data_hold", out_data, cur_data);
            end
            if (out_valid && out_ready) begin
               presenting = 1'b0;
               if (b2b_chk) chk("b2b_in_ready", in_ready, 1'b1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  e;
      bit          errpos[16];
      int          placed;
      bit          seen;
      logic [31:0] y_data;
      rst = 1'b1; in_valid = 1'b0; in_data = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_reset", in_ready, 1'b1);
      @(posedge clk); #1;

      // Directed: clean token, then an errored token.
      send(32'hA5A5_0001, 2'b00, 1'b0, 1'b0);
      send(32'h0000_BEEF, 2'b10, 1'b0, 1'b0);
      wait_idle();
      chk("single_err_cnt", err_cnt, 8'd1);
      chk("single_err_sticky", err_sticky, 2'b10);

      // Window: 3 errors in 16 tokens, then slow-mode tokens, then a clean window.
      do_reset();
      foreach (errpos[i]) errpos[i] = 1'b0;
      placed = 0;
      while (placed < 3) begin
         int p;
         p = $urandom_range(0, 15);
         if (!errpos[p]) begin errpos[p] = 1'b1; placed++; end
      end
      for (int i = 0; i < 16; i++) send($urandom, errpos[i] ? 2'b01 : 2'b00, 1'b0, 1'b0);
      wait_idle();
      chk("slow_after_window", slow_mode, 1'b1);
      send($urandom, 2'b00, 1'b0, 1'b0);
      send($urandom, 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) send($urandom, 2'b00, 1'b0, 1'b0);
      wait_idle();
      chk("slow_cleared", slow_mode, 1'b0);

      // Back-to-back stream, then a 4-cycle downstream stall.
      b2b_chk = 1'b1;
      for (int i = 0; i < 12; i++) begin
         e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send($urandom, e, 1'b0, 1'b1);
      end
      y_data = $urandom;
      send(y_data, 2'b00, 1'b0, 1'b1);
      rdy_mode = 2;
      in_data = 32'hC0DE_0002;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) fail_bound("stall_out_valid");
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("stall_out_data", out_data, y_data);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
      end
      @(posedge clk); #1;
      rdy_mode = 0;
      send(32'hC0DE_0002, 2'b00, 1'b0, 1'b0);
      wait_idle();
      b2b_chk = 1'b0;

      // Clear coinciding with an errored sample, then counter saturation.
      send($urandom, 2'b10, 1'b0, 1'b0);
      send($urandom, 2'b01, 1'b1, 1'b0);
      wait_idle();
      chk("clr_err_cnt", err_cnt, 8'd1);
      chk("clr_err_sticky", err_sticky, 2'b01);
      rdy_mode = 1;
      for (int i = 0; i < 260; i++) send($urandom, 2'($urandom_range(1, 3)), 1'b0, 1'b0);
      wait_idle();
      chk("err_cnt_saturated", err_cnt, 8'hFF);

      // Random mix with gaps, occasional clears and random downstream ready.
      for (int i = 0; i < 40; i++) begin
         e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send($urandom, e, ($urandom_range(0, 7) == 0), 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_idle();

      // Reset while the stage is recovering from an error.
      rdy_mode = 0;
      send(32'h1234_5678, 2'b11, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (sample) seen = 1'b1;
      end
      if (!seen) fail_bound("recover_sample");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;
      exp_q.delete();
      plan_q.delete();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_mid_reset", in_ready, 1'b1);
      @(posedge clk); #1;
      send(32'h0BAD_F00D, 2'b00, 1'b0, 1'b0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
